word_sram_responder: RTL and testbench
======================================

# word_sram_responder

- Responder end of the 16-bit word port (`word_rd`/`word_wr`/`word_addr`/`word_data`/`word_q`/`word_busy`) used by the bridge-side 16-bit streaming controllers.
- Accepts one-cycle read/write command pulses and executes each as a single 16-bit access on an external asynchronous SRAM/PSRAM bus.
- Wait-state counts are programmable by parameter.
- Returns read data with a busy/ready handshake that an initiator checking `word_busy` on the cycle after its pulse can rely on.

## Interface
Parameters:
- MEM_AW, 22, external word-address width; `mem_addr = word_addr[MEM_AW:1]`
- RD_WAIT, 4, cycles OE is held low before read data is sampled (min 1)
- WR_WAIT, 4, cycles WE is held low (min 1)
- TURN, 1, idle cycles after every access before the next is accepted (min 0)

Ports:
- clk_sys  in  1  system clock; the only clock
- reset_l  in  1  asynchronous, active-low reset
- word_rd  in  1  one-cycle read command
- word_wr  in  1  one-cycle write command
- word_addr  in  26  byte address; bit 0 ignored
- word_data  in  16  write data
- word_q  out  16  last read data, held until the next read completes
- word_busy  out  1  access in progress; combinational
- mem_addr  out  MEM_AW  external word address
- mem_dq_out  out  16  external write data
- mem_dq_oe  out  1  data-bus drive enable
- mem_dq_in  in  16  external read data
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low chip enable, output enable, write enable
- cmd_dropped  out  1  one-cycle pulse when a command arrives while busy

## Operation
- State machine states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, TURNAROUND.
  - A single down-counter (width fits the largest of RD_WAIT, WR_WAIT, TURN) times RD_WAIT, WR_PULSE and TURNAROUND.
- `word_busy = busy_reg | ((word_rd | word_wr) & state==IDLE)`.
  - An initiator sampling busy one cycle after its pulse therefore always sees 1.
- IDLE with `word_wr`:
  - Latch address and data.
  - Assert `mem_ce_n`=0 and `mem_dq_oe`=1.
  - Go to WR_SETUP.
- IDLE with `word_rd`:
  - Latch address.
  - Assert `mem_ce_n`=0 and `mem_oe_n`=0.
  - Load counter = RD_WAIT-1 and go to RD_WAIT.
- Simultaneous `word_rd` and `word_wr` in IDLE: the write executes, the read is discarded, and `cmd_dropped` pulses.
- Command while not IDLE: ignored, `cmd_dropped` pulses for one cycle. Address, data and the current access are unaffected.
- RD_WAIT ends when the counter reaches 0:
  - `word_q <= mem_dq_in`.
  - Deassert OE and CE.
  - Go to TURNAROUND, or IDLE if TURN=0.
- WR_SETUP: `mem_we_n`=0, counter = WR_WAIT-1, go to WR_PULSE.
- WR_PULSE ends when the counter reaches 0: `mem_we_n`=1, go to WR_HOLD.
- WR_HOLD: `mem_dq_oe`=0 and `mem_ce_n`=1, go to TURNAROUND or IDLE.
- TURNAROUND: lasts TURN cycles, then IDLE.
- `busy_reg` is set on acceptance and cleared on entry to IDLE.
- Address wraps silently: `word_addr` bits above MEM_AW are ignored.
- Byte lanes: always full 16-bit. No byte swapping here; endianness is the initiator's job.

## Timing
- Acceptance edge is A. Registered memory outputs change at A.
- Read:
  - OE/CE low for cycles A .. A+RD_WAIT-1.
  - `word_q` updates at edge A+RD_WAIT.
  - `word_busy` low from A+RD_WAIT+TURN.
  - `word_q` is valid whenever `word_busy` is low.
- Write:
  - Data and CE from A; WE low A+1 .. A+WR_WAIT.
  - Data driven through A+WR_WAIT+1.
  - `word_busy` low from A+WR_WAIT+2+TURN.
- Back-to-back: a new command is accepted on the first cycle `word_busy` would otherwise be low.
- Reset values (all outputs, immediately on `reset_l` low, including mid-access): `mem_ce_n`=`mem_oe_n`=`mem_we_n`=1, `mem_dq_oe`=0, `mem_addr`=0, `mem_dq_out`=0, `word_q`=0, `busy_reg`=0, `cmd_dropped`=0, state IDLE.
  - An in-flight access is abandoned, not completed.

## Structure
- Shared package: state enum, and default constants for RD_WAIT, WR_WAIT and TURN.
- No sub-module: the FSM and counter stay in one file.

## Test plan
- Write 0xBEEF to byte address 0x000100 (RD_WAIT=WR_WAIT=4, TURN=1) -> `mem_addr`=0x80, WE low exactly 4 cycles starting A+1, `word_busy` low at A+7.
- Read back address 0x000100 with the SRAM model returning 0xBEEF -> `word_q`=0xBEEF at A+4, `word_busy` low at A+5, OE low exactly 4 cycles.
- Initiator-style sequence: pulse `word_rd`, sample `word_busy` next cycle -> 1. Second read of 0x000102 issued the first cycle busy is low -> accepted with no `cmd_dropped`.
- `word_wr` pulsed during RD_WAIT -> `cmd_dropped` pulses once, read completes unchanged, no write reaches the SRAM model.
- Simultaneous `word_rd` and `word_wr` in IDLE -> write executes, `cmd_dropped`=1 for one cycle.
- `reset_l` low at cycle A+2 of a write -> WE, CE, OE high and `mem_dq_oe`=0 with no clock edge; after release, state IDLE and `word_busy`=0.

Source files
------------

// File: rtl/word_sram_responder_pkg.sv
// rtl/word_sram_responder_pkg.sv - shared states and timing defaults for the word SRAM responder
package word_sram_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_TURNAROUND
  } state_t;

  localparam int DEF_RD_WAIT = 4;
  localparam int DEF_WR_WAIT = 4;
  localparam int DEF_TURN    = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/word_sram_responder.sv
// rtl/word_sram_responder.sv - 16-bit word port responder driving an async SRAM/PSRAM bus
module word_sram_responder
  import word_sram_responder_pkg::*;
#(
  parameter int MEM_AW  = 22,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int TURN    = DEF_TURN
) (
  input  logic              clk_sys,
  input  logic              reset_l,
  input  logic              word_rd,
  input  logic              word_wr,
  input  logic [25:0]       word_addr,
  input  logic [15:0]       word_data,
  output logic [15:0]       word_q,
  output logic              word_busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_dq_out,
  output logic              mem_dq_oe,
  input  logic [15:0]       mem_dq_in,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              cmd_dropped
);

  // Counter only ever holds load values (wait - 1), so clog2 of the largest wait suffices.
  localparam int CNT_MAX = max3(RD_WAIT, WR_WAIT, TURN);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'((TURN > 0) ? TURN - 1 : 0);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              busy_reg, busy_nxt;
  logic [15:0]       q_nxt, dq_out_nxt;
  logic [MEM_AW-1:0] addr_nxt;
  logic              dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, dropped_nxt;
  logic              addr_unused;

  // Byte-lane bit 0 and bits above MEM_AW deliberately fall off the end.
  assign addr_unused = ^word_addr;

  assign word_busy = busy_reg | ((word_rd | word_wr) & (state == S_IDLE));

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy_reg    <= 1'b0;
      word_q      <= '0;
      mem_addr    <= '0;
      mem_dq_out  <= '0;
      mem_dq_oe   <= 1'b0;
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      cmd_dropped <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      busy_reg    <= busy_nxt;
      word_q      <= q_nxt;
      mem_addr    <= addr_nxt;
      mem_dq_out  <= dq_out_nxt;
      mem_dq_oe   <= dq_oe_nxt;
      mem_ce_n    <= ce_n_nxt;
      mem_oe_n    <= oe_n_nxt;
      mem_we_n    <= we_n_nxt;
      cmd_dropped <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy_reg;
    q_nxt       = word_q;
    addr_nxt    = mem_addr;
    dq_out_nxt  = mem_dq_out;
    dq_oe_nxt   = mem_dq_oe;
    ce_n_nxt    = mem_ce_n;
    oe_n_nxt    = mem_oe_n;
    we_n_nxt    = mem_we_n;
    dropped_nxt = (state != S_IDLE) & (word_rd | word_wr);

    case (state)
      S_IDLE: begin
        // Write wins a simultaneous request; the read is reported as dropped.
        if (word_wr) begin
          addr_nxt    = word_addr[MEM_AW:1];
          dq_out_nxt  = word_data;
          ce_n_nxt    = 1'b0;
          dq_oe_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          dropped_nxt = word_rd;
          state_nxt   = S_WR_SETUP;
        end else if (word_rd) begin
          addr_nxt  = word_addr[MEM_AW:1];
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = RD_LOAD;
          state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt == '0) begin
          q_nxt    = mem_dq_in;
          oe_n_nxt = 1'b1;
          ce_n_nxt = 1'b1;
          if (TURN > 0) begin
            cnt_nxt   = TURN_LOAD;
            state_nxt = S_TURNAROUND;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WR_SETUP: begin
        we_n_nxt  = 1'b0;
        cnt_nxt   = WR_LOAD;
        state_nxt = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt == '0) begin
          we_n_nxt  = 1'b1;
          state_nxt = S_WR_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WR_HOLD: begin
        dq_oe_nxt = 1'b0;
        ce_n_nxt  = 1'b1;
        if (TURN > 0) begin
          cnt_nxt   = TURN_LOAD;
          state_nxt = S_TURNAROUND;
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_TURNAROUND: begin
        if (cnt == '0) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_word_sram_responder.sv
// tb/tb_word_sram_responder.sv - directed self-checking bench for word_sram_responder
module tb_word_sram_responder;
  import word_sram_responder_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_l;
  logic        word_rd, word_wr;
  logic [25:0] word_addr;
  logic [15:0] word_data;
  logic [15:0] word_q;
  logic        word_busy;
  logic [21:0] mem_addr;
  logic [15:0] mem_dq_out, mem_dq_in;
  logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, cmd_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  word_sram_responder #(
    .MEM_AW(22), .RD_WAIT(4), .WR_WAIT(4), .TURN(1)
  ) dut (
    .clk_sys(clk_sys), .reset_l(reset_l),
    .word_rd(word_rd), .word_wr(word_wr), .word_addr(word_addr), .word_data(word_data),
    .word_q(word_q), .word_busy(word_busy),
    .mem_addr(mem_addr), .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .cmd_dropped(cmd_dropped)
  );

  always #5 clk_sys = ~clk_sys;

  // Async SRAM model: latches on WE rising while selected; word 0x81 is fixed ROM content.
  logic [15:0] sram [256] = '{default: 16'h0000};
  int          wr_count = 0;
  logic        model_en = 1'b0;

  always @(posedge mem_we_n) begin
    if (model_en && mem_ce_n == 1'b0) begin
      sram[mem_addr[7:0]] = mem_dq_out;
      wr_count = wr_count + 1;
    end
  end

  assign mem_dq_in = (!mem_ce_n && !mem_oe_n)
                   ? ((mem_addr == 22'h81) ? 16'h1234 : sram[mem_addr[7:0]]) : 16'h0000;

  logic [15:0] tr_we, tr_oe, tr_dqoe, tr_busy, tr_drop;
  logic [15:0] tr_q [16];
  logic [21:0] tr_addr [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_val(input logic [15:0] v, input logic b, input int n);
    for (int i = 0; i < n; i++) if (v[i] == b) return i;
    return -1;
  endfunction

  function automatic int count_val(input logic [15:0] v, input logic b, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (v[i] == b) c++;
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic rd, input logic wr, input logic [25:0] a, input logic [15:0] d);
    word_rd = rd; word_wr = wr; word_addr = a; word_data = d;
    #1 check_eq("busy_same_cycle", 32'(word_busy), 32'd1);
    @(negedge clk_sys);
    word_rd = 1'b0; word_wr = 1'b0;
  endtask

  // Sample k = 0..n-1 at successive negedges; optionally inject a one-cycle command at inj_k.
  task automatic capture(input int n, input int inj_k, input logic inj_rd, input logic inj_wr,
                         input logic [25:0] inj_a, input logic [15:0] inj_d);
    tr_we = '1; tr_oe = '1; tr_dqoe = '0; tr_busy = '0; tr_drop = '0;
    for (int k = 0; k < n; k++) begin
      tr_we[k]   = mem_we_n;
      tr_oe[k]   = mem_oe_n;
      tr_dqoe[k] = mem_dq_oe;
      tr_busy[k] = word_busy;
      tr_drop[k] = cmd_dropped;
      tr_q[k]    = word_q;
      tr_addr[k] = mem_addr;
      if (k == inj_k + 1) begin word_rd = 1'b0; word_wr = 1'b0; end
      if (k == inj_k) begin
        word_rd = inj_rd; word_wr = inj_wr; word_addr = inj_a; word_data = inj_d;
      end
      @(negedge clk_sys);
    end
  endtask

  initial begin
    reset_l = 1'b1; word_rd = 1'b0; word_wr = 1'b0; word_addr = '0; word_data = '0;
    #2 reset_l = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_l = 1'b1;
    @(negedge clk_sys);
    model_en = 1'b1;

    check_eq("rst_ce_n",   32'(mem_ce_n),    32'd1);
    check_eq("rst_oe_n",   32'(mem_oe_n),    32'd1);
    check_eq("rst_we_n",   32'(mem_we_n),    32'd1);
    check_eq("rst_dq_oe",  32'(mem_dq_oe),   32'd0);
    check_eq("rst_addr",   32'(mem_addr),    32'd0);
    check_eq("rst_dq_out", 32'(mem_dq_out),  32'd0);
    check_eq("rst_q",      32'(word_q),      32'd0);
    check_eq("rst_busy",   32'(word_busy),   32'd0);
    check_eq("rst_drop",   32'(cmd_dropped), 32'd0);

    // Write 0xBEEF to byte 0x100
    issue(1'b0, 1'b1, 26'h000100, 16'hBEEF);
    capture(10, -1, 1'b0, 1'b0, '0, '0);
    check_eq("wr_addr",       32'(tr_addr[0]), 32'h80);
    check_eq("wr_busy_k0",    32'(tr_busy[0]), 32'd1);
    check_eq("wr_we_first",   32'(first_val(tr_we, 1'b0, 10)), 32'd1);
    check_eq("wr_we_len",     32'(count_val(tr_we, 1'b0, 10)), 32'd4);
    check_eq("wr_dqoe_len",   32'(count_val(tr_dqoe, 1'b1, 10)), 32'd6);
    check_eq("wr_busy_low",   32'(first_val(tr_busy, 1'b0, 10)), 32'd7);
    check_eq("wr_mem",        32'(sram[8'h80]), 32'hBEEF);
    check_eq("wr_count",      32'(wr_count), 32'd1);

    // Read back, then back-to-back read issued on first busy-low cycle
    issue(1'b1, 1'b0, 26'h000100, 16'h0000);
    capture(5, -1, 1'b0, 1'b0, '0, '0);
    check_eq("rd_busy_k0",    32'(tr_busy[0]), 32'd1);
    check_eq("rd_oe_first",   32'(first_val(tr_oe, 1'b0, 5)), 32'd0);
    check_eq("rd_oe_len",     32'(count_val(tr_oe, 1'b0, 5)), 32'd4);
    check_eq("rd_q_before",   32'(tr_q[3]), 32'h0);
    check_eq("rd_q_at_a4",    32'(tr_q[4]), 32'hBEEF);
    check_eq("rd_busy_a4",    32'(tr_busy[4]), 32'd1);
    check_eq("rd_busy_a5",    32'(word_busy), 32'd0);
    issue(1'b1, 1'b0, 26'h000102, 16'h0000);
    capture(8, -1, 1'b0, 1'b0, '0, '0);
    check_eq("b2b_drop",      32'(count_val(tr_drop, 1'b1, 8)), 32'd0);
    check_eq("b2b_addr",      32'(tr_addr[0]), 32'h81);
    check_eq("b2b_q",         32'(tr_q[4]), 32'h1234);
    check_eq("b2b_busy_low",  32'(first_val(tr_busy, 1'b0, 8)), 32'd5);

    // Write pulsed during RD_WAIT is dropped
    issue(1'b1, 1'b0, 26'h000100, 16'h0000);
    capture(6, 1, 1'b0, 1'b1, 26'h000104, 16'h5555);
    check_eq("drop_count",    32'(count_val(tr_drop, 1'b1, 6)), 32'd1);
    check_eq("drop_at",       32'(first_val(tr_drop, 1'b1, 6)), 32'd2);
    check_eq("drop_rd_q",     32'(tr_q[4]), 32'hBEEF);
    check_eq("drop_addr",     32'(tr_addr[3]), 32'h80);
    check_eq("drop_no_we",    32'(count_val(tr_we, 1'b0, 6)), 32'd0);
    check_eq("drop_wr_count", 32'(wr_count), 32'd1);
    check_eq("drop_mem82",    32'(sram[8'h82]), 32'h0);

    // Simultaneous rd+wr in IDLE, address with bits above MEM_AW set
    issue(1'b1, 1'b1, 26'h2000106, 16'hA5A5);
    capture(10, -1, 1'b0, 1'b0, '0, '0);
    check_eq("both_drop_k0",  32'(tr_drop[0]), 32'd1);
    check_eq("both_drop_cnt", 32'(count_val(tr_drop, 1'b1, 10)), 32'd1);
    check_eq("both_addr",     32'(tr_addr[0]), 32'h83);
    check_eq("both_no_oe",    32'(count_val(tr_oe, 1'b0, 10)), 32'd0);
    check_eq("both_we_len",   32'(count_val(tr_we, 1'b0, 10)), 32'd4);
    check_eq("both_mem",      32'(sram[8'h83]), 32'hA5A5);
    check_eq("both_wr_count", 32'(wr_count), 32'd2);

    // Reset during a write at A+2
    issue(1'b0, 1'b1, 26'h000108, 16'h7777);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_eq("mid_we_low",    32'(mem_we_n), 32'd0);
    reset_l = 1'b0;
    #1;
    check_eq("arst_we_n",     32'(mem_we_n),  32'd1);
    check_eq("arst_ce_n",     32'(mem_ce_n),  32'd1);
    check_eq("arst_oe_n",     32'(mem_oe_n),  32'd1);
    check_eq("arst_dq_oe",    32'(mem_dq_oe), 32'd0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_l = 1'b1;
    @(negedge clk_sys);
    check_eq("arst_busy",     32'(word_busy), 32'd0);
    check_eq("arst_state",    32'(dut.state), 32'(S_IDLE));
    check_eq("arst_ce_after", 32'(mem_ce_n),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
